regu: RTL and testbench
=======================

# regu

Regulation interlock for one monitored analog channel of the magnet power supply. Each cycle it compares an IEEE-754 single-precision readback (`i_data`) against its set point. When the absolute error exceeds a programmable tolerance for more than a programmable number of consecutive cycles, it latches a fault. The fault stays set until explicitly cleared, and the block feeds the interlock aggregation logic.

## Interface
Parameters:
- `CNT_W`, default 32: width of the consecutive-violation counter; must be ≥ width of `i_delay`.

Ports:
- `i_clk`, in, 1: system clock; all logic on its rising edge.
- `i_rst`, in, 1: reset, asynchronous, active-high; clears all state.
- `i_clr`, in, 1: synchronous fault clear, single-cycle pulse.
- `i_regu_en`, in, 1: 1 = monitoring active.
- `i_set_point`, in, 32: fp32 set point.
- `i_data`, in, 32: fp32 measured value.
- `i_diff`, in, 32: fp32 tolerance; sign bit ignored (magnitude used).
- `i_delay`, in, 32: unsigned number of tolerated consecutive violation cycles.
- `o_over`, out, 1: registered instantaneous violation, |data − set_point| > |diff|.
- `o_fault`, out, 1: latched regulation fault.

## Operation
- Error: e = |i_data − i_set_point|, fp32 subtract, round-to-nearest-even.
- Violation when e > |i_diff| (strict). Equality is not a violation.
- Special operands:
  - Denormal inputs are flushed to ±0.
  - Any NaN operand (data, set point or diff) forces violation (fail-safe).
  - Infinite e forces violation, except inf − inf of the same sign, which is NaN and therefore also a violation.
- Counter `cnt`:
  - `i_regu_en`=0 or `o_over`=0: `cnt` ← 0.
  - Otherwise: `cnt` ← `cnt`+1, saturating at all-ones.
- Fault set: `i_regu_en`=1, `o_over`=1 and `cnt` ≥ `i_delay`. The fault therefore sets after `i_delay`+1 consecutive violating cycles; `i_delay`=0 faults on the first one.
- `o_fault` is sticky. Only `i_clr` or `i_rst` clears it, and `i_clr` also clears `cnt`.
- `i_clr` and a set condition in the same cycle: clear wins for that edge. If the violation persists, the counter restarts from 0 and the fault re-asserts after `i_delay`+1 further violating cycles.
- `i_regu_en` deasserting does not clear an existing fault. It only stops `cnt` and prevents new faults.
- Changing `i_delay` mid-count takes effect immediately against the current `cnt`.

## Timing
- Reset values: `o_over`=0, `o_fault`=0, `cnt`=0, all pipeline registers 0.
- Pipeline from the `i_data`/`i_set_point`/`i_diff` sample edge to `o_over`, 3 cycles:
  - S1 registers the inputs.
  - S2 does exponent compare, alignment and mantissa add/sub.
  - S3 normalizes, takes the magnitude and compares against |diff|; the result drives `o_over`.
- Throughput: one comparison per cycle; no handshake.
- `cnt` and `o_fault` update one edge after `o_over`, so `o_fault` can rise at the earliest 4 cycles after the first violating sample when `i_delay`=0.
- `i_regu_en` and `i_clr` are not pipelined; they act at the counter stage on the edge they are sampled.

## Structure
- Shared package `regu_pkg`:
  - fp32 field constants: sign bit 31, exponent [30:23], mantissa [22:0], bias 127, exponent 0xFF.
  - A typedef for the unpacked fp32 (sign, exp, mant).
  - A NaN-detect function.
- Sub-module `fp32_abs_sub`: 2-stage pipelined |a − b| with NaN flag output (S2–S3 arithmetic).
- The top level holds the input registers, the compare, the counter and the fault latch.

## Test plan
- Reset, then hold setpoint=0x3F99999A (1.2) with data=0x3F99999A, diff=0x3DCCCCCD (0.1), delay=2, en=1 for 20 cycles → `o_over`=0, `o_fault`=0.
- Same configuration, data=0 for exactly 1 cycle then back to 1.2 → `o_over` pulses 1 cycle; `o_fault` stays 0.
- setpoint=0; data 1.2 (1 cycle), 0x3E99999A (0.3, 2 cycles), 0x3F4CCCCD (0.8, 1 cycle), then 0 → 4 consecutive violations, `o_fault` rises 3 edges after `o_over` rises. Data returns to 0 and `o_fault` remains 1; a 1-cycle `i_clr` then gives `o_fault`=0.
- delay=0, data differs from set point by exactly diff (setpoint=1.0, data=1.5, diff=0.5) → no violation. With data=1.5000001 → `o_fault` rises 1 edge after `o_over`.
- data=0x7FC00000 (NaN), en=1, delay=0 → `o_over`=1 and `o_fault`=1. Same stimulus with en=0 → `o_over`=1, `o_fault` stays 0.
- Assert `i_rst` mid-count with `o_fault`=1 → both outputs 0 immediately (asynchronous). After release, the counter starts from 0.

Source files
------------

// File: rtl/regu_pkg.sv
// Shared fp32 definitions for the regulation interlock datapath.
package regu_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_W   = 23;
    localparam int EXP_BIAS = 127;
    localparam logic [7:0] EXP_MAX = 8'hFF;

    localparam logic [30:0] MAG_QNAN = 31'h7FC00000;
    localparam logic [30:0] MAG_INF  = 31'h7F800000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    function automatic logic is_nan(input fp32_t f);
        return (f.exp == EXP_MAX) && (f.mant != '0);
    endfunction

    function automatic logic is_inf(input fp32_t f);
        return (f.exp == EXP_MAX) && (f.mant == '0);
    endfunction

    function automatic fp32_t flush_denorm(input fp32_t f);
        fp32_t r;
        r = f;
        if (f.exp == '0)
            r.mant = '0;
        return r;
    endfunction

endpackage

// File: rtl/fp32_abs_sub.sv
// |a - b| for fp32: alignment and add/sub registered, then normalize and round to nearest-even.
// Denormal operands flush to zero, and a result that would be denormal also flushes to zero.
module fp32_abs_sub
    import regu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [30:0] mag,
    output logic        nan
);

    fp32_t       fa, fb;
    logic        eff_sub, swap;
    logic [7:0]  ex, ey, d;
    logic [23:0] mx, my;
    logic [4:0]  d_c;
    logic [53:0] y_sh;
    logic [26:0] y_al;
    logic [27:0] sum_d;
    logic        nan_d, inf_d;

    assign fa = flush_denorm(fp32_t'(a));
    assign fb = flush_denorm(fp32_t'(b));

    // Only the magnitude matters, so work on |x| +/- |y| with x the larger operand.
    assign eff_sub = (fa.sign == fb.sign);
    assign swap    = {fb.exp, fb.mant} > {fa.exp, fa.mant};
    assign ex      = swap ? fb.exp : fa.exp;
    assign ey      = swap ? fa.exp : fb.exp;
    assign mx      = swap ? {fb.exp != '0, fb.mant} : {fa.exp != '0, fa.mant};
    assign my      = swap ? {fa.exp != '0, fa.mant} : {fb.exp != '0, fb.mant};
    assign d       = ex - ey;
    assign d_c     = (d > 8'd27) ? 5'd27 : d[4:0];
    assign y_sh    = {my, 30'b0} >> d_c;
    assign y_al    = {y_sh[53:28], y_sh[27] | (|y_sh[26:0])};
    assign sum_d   = eff_sub ? ({1'b0, mx, 3'b000} - {1'b0, y_al})
                             : ({1'b0, mx, 3'b000} + {1'b0, y_al});
    assign nan_d   = is_nan(fa) | is_nan(fb) | (is_inf(fa) & is_inf(fb) & eff_sub);
    assign inf_d   = is_inf(fa) | is_inf(fb);

    logic [27:0] sum_q;
    logic [7:0]  exp_q;
    logic        nan_q, inf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            exp_q <= '0;
            nan_q <= 1'b0;
            inf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            exp_q <= ex;
            nan_q <= nan_d;
            inf_q <= inf_d;
        end
    end

    logic [4:0]        lz;
    logic [26:0]       norm;
    logic signed [9:0] e_n, e_r;
    logic              round_up;
    logic [24:0]       mant_r;
    logic [22:0]       frac;

    always_comb begin
        lz = '0;
        for (int i = 0; i < 27; i++)
            if (sum_q[i])
                lz = 5'(26 - i);
        if (sum_q[27]) begin
            norm = {sum_q[27:2], sum_q[1] | sum_q[0]};
            e_n  = $signed({2'b00, exp_q}) + 10'sd1;
        end else begin
            norm = sum_q[26:0] << lz;
            e_n  = $signed({2'b00, exp_q}) - $signed({5'b00000, lz});
        end
        round_up = norm[2] & (norm[3] | norm[1] | norm[0]);
        mant_r   = {1'b0, norm[26:3]} + {24'b0, round_up};
        e_r      = mant_r[24] ? e_n + 10'sd1 : e_n;
        frac     = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        if (nan_q)
            mag = MAG_QNAN;
        else if (inf_q)
            mag = MAG_INF;
        else if (sum_q == '0 || e_r <= 10'sd0)
            mag = '0;
        else if (e_r >= 10'sd255)
            mag = MAG_INF;
        else
            mag = {e_r[7:0], frac};
    end

    assign nan = nan_q;

endmodule

// File: rtl/regu.sv
// Regulation interlock: flags |data - set_point| > |diff| and latches a fault after
// more than i_delay consecutive violating cycles while monitoring is enabled.
module regu
    import regu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_regu_en,
    input  logic [31:0] i_set_point,
    input  logic [31:0] i_data,
    input  logic [31:0] i_diff,
    input  logic [31:0] i_delay,
    output logic        o_over,
    output logic        o_fault
);

    logic [31:0] data_q, set_q;
    logic [30:0] diff_q, diff_q2;
    logic        unused_diff_sign;

    // The tolerance is a magnitude; its sign bit is dropped at the input register.
    assign unused_diff_sign = i_diff[31];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q  <= '0;
            set_q   <= '0;
            diff_q  <= '0;
            diff_q2 <= '0;
        end else begin
            data_q  <= i_data;
            set_q   <= i_set_point;
            diff_q  <= i_diff[30:0];
            diff_q2 <= diff_q;
        end
    end

    logic [30:0] err_mag;
    logic        err_nan;

    fp32_abs_sub u_abs_sub (
        .clk (i_clk),
        .rst (i_rst),
        .a   (data_q),
        .b   (set_q),
        .mag (err_mag),
        .nan (err_nan)
    );

    fp32_t       diff_f;
    logic [30:0] diff_mag;
    logic        over_d;

    assign diff_f   = fp32_t'({1'b0, diff_q2});
    assign diff_mag = (diff_f.exp == '0) ? '0 : diff_q2;
    assign over_d   = err_nan | is_nan(diff_f) | (err_mag[30:23] == EXP_MAX) | (err_mag > diff_mag);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] delay_ext;

    assign delay_ext = CNT_W'(i_delay);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_over  <= 1'b0;
            cnt     <= '0;
            o_fault <= 1'b0;
        end else begin
            o_over <= over_d;
            if (i_clr || !i_regu_en || !o_over)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + CNT_W'(1);
            // Clear takes priority over a simultaneous set condition.
            if (i_clr)
                o_fault <= 1'b0;
            else if (i_regu_en && o_over && cnt >= delay_ext)
                o_fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regu.sv
// Directed bench for the regulation interlock with hand-computed expectations.
module tb_regu;

    localparam logic [31:0] F_0    = 32'h00000000;
    localparam logic [31:0] F_0P1  = 32'h3DCCCCCD;
    localparam logic [31:0] F_0P3  = 32'h3E99999A;
    localparam logic [31:0] F_0P5  = 32'h3F000000;
    localparam logic [31:0] F_0P8  = 32'h3F4CCCCD;
    localparam logic [31:0] F_1P0  = 32'h3F800000;
    localparam logic [31:0] F_1P2  = 32'h3F99999A;
    localparam logic [31:0] F_1P5  = 32'h3FC00000;
    localparam logic [31:0] F_1P5P = 32'h3FC00001;
    localparam logic [31:0] F_QNAN = 32'h7FC00000;

    logic        i_clk = 1'b0;
    logic        i_rst, i_clr, i_regu_en;
    logic [31:0] i_set_point, i_data, i_diff, i_delay;
    logic        o_over, o_fault;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] vec_data [10] = '{32'h3F800000, 32'h3F800000, 32'h00000001, 32'h7F800000, 32'h3F800000,
                                   32'h7F800000, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h3F800000, 32'h3F800000};
    logic [31:0] vec_set  [10] = '{32'h3F800000, 32'h3F800000, 32'h00000000, 32'h7F800000, 32'h3F800000,
                                   32'hFF800000, 32'h00000000, 32'hFF7FFFFF, 32'h33000000, 32'h33000000};
    logic [31:0] vec_diff [10] = '{32'h3F000000, 32'h7F800001, 32'h00000000, 32'h3F000000, 32'h3F000000,
                                   32'h3F000000, 32'h7F800000, 32'h7F800000, 32'h3F7FFFFF, 32'h3F800000};
    logic        vec_over [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    always #5 i_clk = ~i_clk;

    regu #(.CNT_W(32)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (i_clr),
        .i_regu_en   (i_regu_en),
        .i_set_point (i_set_point),
        .i_data      (i_data),
        .i_diff      (i_diff),
        .i_delay     (i_delay),
        .o_over      (o_over),
        .o_fault     (o_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
        n_checks++;
        if (got !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    initial begin
        i_rst = 1'b1;
        i_clr = 1'b0;
        i_regu_en = 1'b0;
        i_set_point = F_0;
        i_data = F_0;
        i_diff = F_0;
        i_delay = 32'd0;
        tick(2);
        check("rst_over", o_over, 0);
        check("rst_fault", o_fault, 0);
        i_rst = 1'b0;

        // Matching readback: never a violation.
        i_set_point = F_1P2; i_data = F_1P2; i_diff = F_0P1; i_delay = 32'd2; i_regu_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            check("hold_over", o_over, 0);
            check("hold_fault", o_fault, 0);
        end

        // Single-cycle glitch: o_over pulses once, no fault.
        i_data = F_0;
        tick(1); i_data = F_1P2;
        tick(1); check("glitch_pre", o_over, 0);
        tick(1); check("glitch_on", o_over, 1);
        tick(1); check("glitch_off", o_over, 0);
        check("glitch_fault", o_fault, 0);
        tick(3); check("glitch_fault_late", o_fault, 0);

        // Four violating samples with delay=2.
        i_set_point = F_0; i_data = F_1P2;
        tick(1); i_data = F_0P3;
        tick(2); check("seq_over_rise", o_over, 1); check("seq_fault_n3", o_fault, 0);
        i_data = F_0P8;
        tick(1); i_data = F_0;
        check("seq_fault_n4", o_fault, 0);
        tick(1); check("seq_fault_n5", o_fault, 0); check("seq_over_n5", o_over, 1);
        tick(1); check("seq_fault_rise", o_fault, 1);
        tick(1); check("seq_over_fall", o_over, 0); check("seq_fault_hold", o_fault, 1);
        tick(5); check("seq_sticky", o_fault, 1);
        i_clr = 1'b1; tick(1); i_clr = 1'b0;
        check("seq_clr", o_fault, 0);

        // Equality at the tolerance is not a violation; tolerance sign ignored.
        i_delay = 32'd0; i_set_point = F_1P0; i_data = F_1P5; i_diff = F_0P5;
        tick(5); check("eq_over", o_over, 0); check("eq_fault", o_fault, 0);
        i_diff = 32'hBF000000;
        tick(4); check("neg_tol_over", o_over, 0);
        i_data = F_1P5P;
        tick(3); check("ulp_over", o_over, 1); check("ulp_fault_n3", o_fault, 0);
        tick(1); check("ulp_fault", o_fault, 1);
        i_clr = 1'b1; tick(1); i_clr = 1'b0;
        check("clr_wins", o_fault, 0);
        tick(1); check("refault", o_fault, 1);
        i_data = F_1P5;
        tick(3); check("ulp_back_over", o_over, 0);
        i_clr = 1'b1; tick(1); i_clr = 1'b0;
        check("ulp_back_clr", o_fault, 0);

        // NaN readback is fail-safe; disabling keeps but never sets the fault.
        i_diff = F_0P5; i_data = F_QNAN;
        tick(3); check("nan_over", o_over, 1);
        tick(1); check("nan_fault", o_fault, 1);
        i_regu_en = 1'b0;
        tick(1); check("en_off_keeps", o_fault, 1);
        i_clr = 1'b1; tick(1); i_clr = 1'b0;
        check("en_off_clr", o_fault, 0);
        tick(3); check("nan_en0_over", o_over, 1); check("nan_en0_fault", o_fault, 0);

        // Special-operand and rounding vectors (monitoring off, only o_over checked).
        for (int k = 0; k < 10; k++) begin
            i_data = vec_data[k]; i_set_point = vec_set[k]; i_diff = vec_diff[k];
            tick(3);
            check($sformatf("vec%0d_over", k), o_over, 32'(vec_over[k]));
        end
        check("vec_fault", o_fault, 0);

        // Asynchronous reset mid-count, then restart of the counter from zero.
        i_regu_en = 1'b1; i_data = F_QNAN; i_set_point = F_1P0; i_diff = F_0P5; i_delay = 32'd0;
        tick(4); check("pre_rst_fault", o_fault, 1);
        i_delay = 32'd3;
        tick(2);
        #2 i_rst = 1'b1;
        #1 check("async_rst_over", o_over, 0);
        check("async_rst_fault", o_fault, 0);
        tick(1); i_rst = 1'b0;
        tick(3); check("post_rst_over", o_over, 1); check("post_rst_n3", o_fault, 0);
        tick(3); check("post_rst_n6", o_fault, 0);
        tick(1); check("post_rst_fault", o_fault, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
